// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding and a conditional negate helper.
package mdu_pkg;

    // Upper bound on any value passed through condNeg (2*WIDTH must not exceed it).
    localparam int MDU_MAX_W = 128;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mduOp_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } mduState_t;

    // Two's-complement negate when neg is set. Callers zero-extend into
    // MDU_MAX_W bits and size-cast the result back; the low bits are exact.
    function automatic logic [MDU_MAX_W-1:0] condNeg(input logic [MDU_MAX_W-1:0] x,
                                                     input logic                 neg);
        return neg ? (~x + MDU_MAX_W'(1)) : x;
    endfunction

endpackage

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// One bit per cycle: shift-add multiply, restoring divide, then a sign
// fix-up cycle that writes HI/LO and pulses Done.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             Flush,
    input  logic             WriteHI,
    input  logic             WriteLO,
    input  logic [WIDTH-1:0] WData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    mduState_t          state, stateNext;
    logic [CNT_W-1:0]   cnt;
    logic               accept, lastIter;

    mduOp_t             opSel;
    logic               isSignedOp, negA, negB;
    logic [WIDTH:0]     extA, extB;
    logic [WIDTH-1:0]   magA, magB;

    // Shared iteration register: {hi, lo} for multiply, {remainder, quotient} for divide.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opB;
    logic [WIDTH-1:0]   rawA;
    logic               isDiv, negRes, negRem, divZero;

    logic [WIDTH:0]     mulSum, divShift;
    logic               divFits;
    logic [WIDTH-1:0]   divRem;

    logic [2*WIDTH-1:0] prodFix;
    logic [WIDTH-1:0]   quoFix, remFix, hiFix, loFix;

    assign Busy     = (state != IDLE);
    assign accept   = (state == IDLE) && Start && !Flush;
    assign lastIter = (cnt == CNT_W'(WIDTH - 1));

    // Operand capture: magnitudes are formed on WIDTH+1 bits so |MIN| survives.
    always_comb begin
        opSel      = mduOp_t'(Op);
        isSignedOp = (opSel == OP_MULT) || (opSel == OP_DIV);
        negA       = isSignedOp && SrcA[WIDTH-1];
        negB       = isSignedOp && SrcB[WIDTH-1];
        extA       = {negA, SrcA};
        extB       = {negB, SrcB};
        magA       = WIDTH'(condNeg(MDU_MAX_W'(extA), negA));
        magB       = WIDTH'(condNeg(MDU_MAX_W'(extB), negB));
    end

    // One iteration step for each algorithm, selected when the register updates.
    always_comb begin
        mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
        divShift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        divFits  = (divShift >= {1'b0, opB});
        divRem   = divFits ? WIDTH'(divShift - {1'b0, opB}) : divShift[WIDTH-1:0];
    end

    // Sign correction and special cases. MIN/-1 needs no special path: the
    // unsigned quotient 2^(WIDTH-1) with no negation already reads as MIN, rem 0.
    always_comb begin
        prodFix = (2*WIDTH)'(condNeg(MDU_MAX_W'(acc), negRes));
        quoFix  = WIDTH'(condNeg(MDU_MAX_W'(acc[WIDTH-1:0]), negRes));
        remFix  = WIDTH'(condNeg(MDU_MAX_W'(acc[2*WIDTH-1:WIDTH]), negRem));
        if (divZero) begin
            hiFix = rawA;
            loFix = '1;
        end else if (isDiv) begin
            hiFix = remFix;
            loFix = quoFix;
        end else begin
            hiFix = prodFix[2*WIDTH-1:WIDTH];
            loFix = prodFix[WIDTH-1:0];
        end
    end

    // Next-state logic: Flush aborts any in-flight op and blocks a same-cycle start.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (Start && !Flush) stateNext = RUN;
            RUN:     if (Flush) stateNext = IDLE;
                     else if (lastIter) stateNext = FIX;
            FIX:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // State register and iteration counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            if (accept) begin
                cnt <= '0;
            end else if (state == RUN) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Architectural HI/LO and the Done pulse; MTHI/MTLO only land while idle.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Done <= 1'b0;
            HI   <= '0;
            LO   <= '0;
        end else begin
            Done <= (state == FIX) && !Flush;
            if ((state == FIX) && !Flush) begin
                HI <= hiFix;
                LO <= loFix;
            end else if (state == IDLE) begin
                if (WriteHI) HI <= WData;
                if (WriteLO) LO <= WData;
            end
        end
    end

    // Iteration datapath; contents are only meaningful between accept and FIX.
    always_ff @(posedge CLK) begin
        if (accept) begin
            acc     <= {{WIDTH{1'b0}}, magA};
            opB     <= magB;
            rawA    <= SrcA;
            isDiv   <= Op[1];
            negRes  <= negA ^ negB;
            negRem  <= negA;
            divZero <= Op[1] && (SrcB == '0);
        end else if (state == RUN) begin
            if (isDiv) begin
                acc <= {divRem, acc[WIDTH-2:0], divFits};
            end else begin
                acc <= {mulSum, acc[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mdu_iterative.sv
// Self-checking bench for mdu_iterative (WIDTH=32): directed cases with
// literal expectations plus randomized ops against a cycle-level reference.
module tb_mdu_iterative;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         Start = 1'b0;
    logic [1:0]   Op = 2'b00;
    logic [W-1:0] SrcA = '0;
    logic [W-1:0] SrcB = '0;
    logic         Flush = 1'b0;
    logic         WriteHI = 1'b0;
    logic         WriteLO = 1'b0;
    logic [W-1:0] WData = '0;
    logic         Busy, Done;
    logic [W-1:0] HI, LO;

    int nCmp = 0;
    int nFail = 0;
    bit checkEn = 1'b0;

    mdu_iterative #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
        .Flush(Flush), .WriteHI(WriteHI), .WriteLO(WriteLO), .WData(WData),
        .Busy(Busy), .Done(Done), .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nCmp++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference result {HI, LO} from plain 64-bit arithmetic.
    function automatic logic [63:0] refMdu(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        longint          sa, sb, sp;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        ub = longint'({32'h0, b});
        case (op)
            2'b00: begin sp = sa * sb; return 64'(sp); end
            2'b01: begin up = ua * ub; return up; end
            2'b10: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
    endfunction

    // Cycle-level reference: an op occupies W+1 cycles then its result lands.
    logic [31:0] eHI = '0, eLO = '0;
    logic        eDone = 1'b0, eBusy = 1'b0;
    int          remaining = 0;
    logic [63:0] pendRes = '0;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            eHI = '0; eLO = '0; eDone = 1'b0; eBusy = 1'b0; remaining = 0;
        end else begin
            eDone = 1'b0;
            if (remaining > 0) begin
                if (Flush) begin
                    remaining = 0;
                end else begin
                    remaining--;
                    if (remaining == 0) begin
                        {eHI, eLO} = pendRes;
                        eDone = 1'b1;
                    end
                end
            end else begin
                if (WriteHI) eHI = WData;
                if (WriteLO) eLO = WData;
                if (Start && !Flush) begin
                    remaining = W + 1;
                    pendRes = refMdu(Op, SrcA, SrcB);
                end
            end
            eBusy = (remaining > 0);
        end
    end

    // Compare every cycle against the reference.
    always @(negedge CLK) begin
        if (checkEn && !RST) begin
            check("busy", 64'(Busy), 64'(eBusy));
            check("done", 64'(Done), 64'(eDone));
            check("hi", 64'(HI), 64'(eHI));
            check("lo", 64'(LO), 64'(eLO));
        end
    end

    task automatic startOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCnt);
        lat = 0;
        busyCnt = 0;
        while (!Done && lat < 100) begin
            if (Busy) busyCnt++;
            @(negedge CLK);
            lat++;
        end
        if (!Done) check("done_timeout", 64'(Done), 64'd1);
    endtask

    task automatic runOp(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expHi, input logic [31:0] expLo);
        int lat, bc;
        startOp(op, a, b);
        waitDone(lat, bc);
        check({name, "_latency"}, 64'(lat), 64'd33);
        check({name, "_busycycles"}, 64'(bc), 64'd33);
        check({name, "_hi"}, 64'(HI), 64'(expHi));
        check({name, "_lo"}, 64'(LO), 64'(expLo));
    endtask

    task automatic writeHiLo(input logic [31:0] h, input logic [31:0] l);
        @(negedge CLK); WriteHI = 1'b1; WData = h;
        @(negedge CLK); WriteHI = 1'b0; WriteLO = 1'b1; WData = l;
        @(negedge CLK); WriteLO = 1'b0;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            4: return 32'h0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat, bc, doneCnt, k;
        repeat (3) @(negedge CLK);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_hi", 64'(HI), 64'd0);
        check("rst_lo", 64'(LO), 64'd0);
        RST = 1'b0;
        checkEn = 1'b1;

        runOp("multu_ff_x2", 2'b01, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE);
        runOp("mult_m1_x2", 2'b00, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE);
        runOp("mult_min_min", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        runOp("div_m7_2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("divu_7_0", 2'b11, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        runOp("div_m7_0", 2'b10, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        runOp("div_min_m1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);

        // Async reset between clock edges mid-MULT.
        writeHiLo(32'hDEAD0001, 32'hBEEF0002);
        startOp(2'b00, 32'd12345, 32'd678);
        repeat (5) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("arst_busy", 64'(Busy), 64'd0);
        check("arst_done", 64'(Done), 64'd0);
        check("arst_hi", 64'(HI), 64'd0);
        check("arst_lo", 64'(LO), 64'd0);
        @(negedge CLK);
        RST = 1'b0;

        // Flush mid-op keeps preloaded HI/LO; an immediate restart completes.
        writeHiLo(32'h11, 32'h22);
        startOp(2'b11, 32'd100, 32'd3);
        repeat (9) @(negedge CLK);
        Flush = 1'b1;
        @(negedge CLK);
        Flush = 1'b0;
        check("flush_busy", 64'(Busy), 64'd0);
        check("flush_hi", 64'(HI), 64'h11);
        check("flush_lo", 64'(LO), 64'h22);
        runOp("divu_100_3", 2'b11, 32'd100, 32'd3, 32'd1, 32'd33);

        // Flush and Start together in IDLE: no start.
        @(negedge CLK);
        Start = 1'b1; Flush = 1'b1; Op = 2'b01; SrcA = 32'd9; SrcB = 32'd9;
        @(negedge CLK);
        Start = 1'b0; Flush = 1'b0;
        check("flush_start_busy", 64'(Busy), 64'd0);

        // Repeated Start while busy is ignored; exactly one Done.
        startOp(2'b01, 32'd1234, 32'd5678);
        doneCnt = 0;
        for (int i = 0; i < 60; i++) begin
            if (Done) doneCnt++;
            Start = (i < 25) && (i % 2 == 0);
            Op = 2'($urandom_range(0, 3));
            SrcA = $urandom;
            SrcB = $urandom;
            @(negedge CLK);
        end
        Start = 1'b0;
        check("busy_start_donecnt", 64'(doneCnt), 64'd1);
        check("busy_start_hi", 64'(HI), 64'h0);
        check("busy_start_lo", 64'(LO), 64'h006AE9BC);

        // Randomized ops, with occasional MTHI/MTLO and mid-op flushes.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) == 0) writeHiLo($urandom, $urandom);
            startOp(2'($urandom_range(0, 3)), pick(), pick());
            if ($urandom_range(0, 4) == 0) begin
                k = $urandom_range(0, 32);
                repeat (k) @(negedge CLK);
                Flush = 1'b1;
                @(negedge CLK);
                Flush = 1'b0;
            end else begin
                waitDone(lat, bc);
            end
            @(negedge CLK);
        end

        repeat (2) @(negedge CLK);
        checkEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
        $finish;
    end

endmodule
